// File: rtl/sfp_link_pkg.sv
// Shared types and sizing helpers for the SFP link supervisor.
package sfp_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_WAIT_RX  = 3'd2,
        ST_DEBOUNCE = 3'd3,
        ST_UP       = 3'd4,
        ST_BACKOFF  = 3'd5
    } chan_state_t;

    // Bits needed to hold values 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sfp_link_chan_fsm.sv
// One channel's bring-up FSM: reset hold, lock wait with timeout, debounce,
// backoff/retry and a saturating failure counter.
module sfp_link_chan_fsm
    import sfp_link_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int BACKOFF_CYC  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int DEBOUNCE     = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             rx_ready,
    input  logic             fail_clr,
    output logic             chan_rst,
    output logic             tx_disable,
    output logic             link_up,
    output logic [CNT_W-1:0] fail_cnt
);

    // One phase counter serves RESET, DEBOUNCE and BACKOFF since they never overlap.
    localparam int PH_W  = cnt_width(max3(RST_HOLD, DEBOUNCE, BACKOFF_CYC));
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT);

    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_HOLD - 1);
    localparam logic [PH_W-1:0]  DEB_LAST = PH_W'(DEBOUNCE - 1);
    localparam logic [PH_W-1:0]  BO_LAST  = PH_W'(BACKOFF_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    chan_state_t      state, state_nxt;
    logic [PH_W-1:0]  ph_cnt, ph_cnt_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic [CNT_W-1:0] fail_nxt;
    logic             fail_evt;
    logic             tmo_exp;

    assign tmo_exp = (tmo >= TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ph_cnt   <= '0;
            tmo      <= '0;
            fail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ph_cnt   <= ph_cnt_nxt;
            tmo      <= tmo_nxt;
            fail_cnt <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ph_cnt_nxt = ph_cnt;
        tmo_nxt    = tmo;
        fail_evt   = 1'b0;

        if (!go) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt  = ST_RESET;
                    ph_cnt_nxt = '0;
                end
                ST_RESET: begin
                    if (ph_cnt >= RST_LAST) begin
                        state_nxt = ST_WAIT_RX;
                        tmo_nxt   = '0;
                    end else begin
                        ph_cnt_nxt = ph_cnt + 1'b1;
                    end
                end
                ST_WAIT_RX: begin
                    if (tmo_exp) begin
                        state_nxt  = ST_BACKOFF;
                        ph_cnt_nxt = '0;
                        fail_evt   = 1'b1;
                    end else begin
                        tmo_nxt = tmo + 1'b1;
                        if (rx_ready) begin
                            state_nxt  = ST_DEBOUNCE;
                            ph_cnt_nxt = '0;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!tmo_exp) tmo_nxt = tmo + 1'b1;
                    // Completing the debounce beats a timeout landing on the same cycle.
                    if (rx_ready && ph_cnt >= DEB_LAST) begin
                        state_nxt = ST_UP;
                    end else if (tmo_exp) begin
                        state_nxt  = ST_BACKOFF;
                        ph_cnt_nxt = '0;
                        fail_evt   = 1'b1;
                    end else if (!rx_ready) begin
                        state_nxt = ST_WAIT_RX;
                    end else begin
                        ph_cnt_nxt = ph_cnt + 1'b1;
                    end
                end
                ST_UP: begin
                    if (!rx_ready) begin
                        state_nxt  = ST_BACKOFF;
                        ph_cnt_nxt = '0;
                        fail_evt   = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (ph_cnt >= BO_LAST) begin
                        state_nxt  = ST_RESET;
                        ph_cnt_nxt = '0;
                    end else begin
                        ph_cnt_nxt = ph_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (fail_clr)
            fail_nxt = '0;
        else if (fail_evt && (fail_cnt != {CNT_W{1'b1}}))
            fail_nxt = fail_cnt + 1'b1;
        else
            fail_nxt = fail_cnt;
    end

    assign chan_rst   = (state == ST_IDLE) || (state == ST_RESET) || (state == ST_BACKOFF);
    assign tx_disable = (state == ST_IDLE);
    assign link_up    = (state == ST_UP);

endmodule

// File: rtl/sfp_link_supervisor.sv
// Multi-channel SFP link supervisor: global readiness qualifier, per-channel
// bring-up FSMs and the registered all-links-up summary.
module sfp_link_supervisor
    import sfp_link_pkg::*;
#(
    parameter int N_CH         = 1,
    parameter int RST_HOLD     = 16,
    parameter int BACKOFF_CYC  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int DEBOUNCE     = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_ready,
    input  logic                  pll_locked,
    input  logic                  reconfig_busy,
    input  logic [N_CH-1:0]       chan_en,
    input  logic [N_CH-1:0]       rx_ready,
    input  logic                  fail_clr,
    output logic [N_CH-1:0]       chan_rst,
    output logic [N_CH-1:0]       tx_disable,
    output logic [N_CH-1:0]       link_up,
    output logic                  all_up,
    output logic [N_CH*CNT_W-1:0] fail_cnt
);

    logic            q;
    logic [N_CH-1:0] go;
    logic            all_up_nxt;

    assign q  = clk_ready & pll_locked & ~reconfig_busy;
    assign go = chan_en & {N_CH{q}};

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        sfp_link_chan_fsm #(
            .RST_HOLD    (RST_HOLD),
            .BACKOFF_CYC (BACKOFF_CYC),
            .LOCK_TIMEOUT(LOCK_TIMEOUT),
            .DEBOUNCE    (DEBOUNCE),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .go        (go[i]),
            .rx_ready  (rx_ready[i]),
            .fail_clr  (fail_clr),
            .chan_rst  (chan_rst[i]),
            .tx_disable(tx_disable[i]),
            .link_up   (link_up[i]),
            .fail_cnt  (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Disabled channels don't hold the summary low, but no enabled channels means not up.
    assign all_up_nxt = (|chan_en) & (&(link_up | ~chan_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) all_up <= 1'b0;
        else     all_up <= all_up_nxt;
    end

endmodule

// File: doc/sfp_link_supervisor.md
Name: sfp_link_supervisor

Overview:
- Parametrised per-channel bring-up and supervision controller for N SFP/10GBASE-R channels.
- Sits between clock-chip init / PHY PLL / reconfig status and the per-channel PHY and MAC resets.
- Sequences channel reset release, waits for receive lock with timeout, debounces lock, flags link-up, and retries automatically on failure or loss.
- Counts failures per channel; drives per-channel SFP TX disable.

Parameters:
- N_CH, 1, number of supervised channels (1..8).
- RST_HOLD, 16, cycles chan_rst is held in RESET state (>=1).
- BACKOFF_CYC, 1024, cycles spent in BACKOFF before a retry (>=1).
- LOCK_TIMEOUT, 1000000, cycles allowed in WAIT_RX+DEBOUNCE before declaring failure.
- DEBOUNCE, 1024, consecutive rx_ready-high cycles required before UP (>=1).
- CNT_W, 16, width of each failure counter.

Ports:
- clk  in  1  supervision clock; all inputs are synchronous to it (synchronised upstream).
- rst  in  1  asynchronous, active-high reset.
- clk_ready  in  1  reference clock chip initialised.
- pll_locked  in  1  PHY transmit PLL locked.
- reconfig_busy  in  1  transceiver reconfig controller busy.
- chan_en  in  N_CH  per-channel enable.
- rx_ready  in  N_CH  per-channel receive block lock / ready.
- fail_clr  in  1  single-cycle pulse, clears all failure counters.
- chan_rst  out  N_CH  per-channel PHY/MAC reset, active-high.
- tx_disable  out  N_CH  per-channel SFP TX disable.
- link_up  out  N_CH  channel in UP state.
- all_up  out  1  all enabled channels up.
- fail_cnt  out  N_CH*CNT_W  saturating failure counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset values: chan_rst all 1, tx_disable all 1, link_up 0, all_up 0, fail_cnt 0, every channel FSM in IDLE.
- Global qualifier: q = clk_ready & pll_locked & ~reconfig_busy. Per channel: go_i = q & chan_en[i].
- All outputs are registered. chan_rst, tx_disable and link_up are decoded from the state register.
- IDLE: chan_rst=1, tx_disable=1. go_i -> RESET.
- RESET: chan_rst=1, tx_disable=0. Stay exactly RST_HOLD cycles, then -> WAIT_RX. Timeout timer cleared on this exit.
- WAIT_RX: chan_rst=0, tx_disable=0. Timeout timer increments each cycle.
  - rx_ready=1 -> DEBOUNCE, with the debounce counter cleared.
  - Timer reaches LOCK_TIMEOUT -> BACKOFF, fail_cnt++.
- DEBOUNCE: chan_rst=0. Timeout timer keeps running.
  - rx_ready=0 -> WAIT_RX.
  - rx_ready high for DEBOUNCE consecutive cycles -> UP.
  - Timeout expiring on the same cycle as debounce completion: UP wins.
  - Timeout expiring otherwise -> BACKOFF, fail_cnt++.
- UP: link_up=1, chan_rst=0. rx_ready=0 -> BACKOFF, fail_cnt++.
- BACKOFF: chan_rst=1, tx_disable=0. Stay BACKOFF_CYC cycles, then -> RESET.
- Abort: go_i=0 in any non-IDLE state -> IDLE next edge.
  - No fail_cnt increment.
  - Abort has priority over every other transition.
- Minimum latency, with rx_ready held high: link_up rises 2+RST_HOLD+DEBOUNCE edges after the first edge that samples go_i=1.
- fail_cnt saturates at 2^CNT_W-1 (no wrap). fail_clr zeroes all counters next edge; clear beats a simultaneous increment (result 0).
- all_up = AND over i of (link_up[i] | ~chan_en[i]), forced to 0 when chan_en==0. Registered, so it lags link_up by one cycle.
- Counter widths are sized with $clog2 of their limit (+1). Timer compares use >= so a mid-count parameter edge case cannot overrun.
- rst asserted mid-operation returns every channel to IDLE immediately (asynchronously), with outputs at their reset values.

Decomposition:
- Package sfp_link_pkg:
  - State enum: IDLE, RESET, WAIT_RX, DEBOUNCE, UP, BACKOFF (3-bit encoding).
  - Width helper function.
- Sub-module sfp_link_chan_fsm: one channel's FSM, timers and saturating counter.
  - Instantiated N_CH times in a generate loop.
  - Top level holds the qualifier logic and the all_up register.

Test Plan (N_CH=2, RST_HOLD=4, DEBOUNCE=8, LOCK_TIMEOUT=64, BACKOFF_CYC=16, CNT_W=4):
- Nominal: after rst, raise q, chan_en=2'b01, rx_ready=2'b11 -> chan_rst[0] falls after edge 5, link_up[0] rises after edge 14, all_up after edge 15; channel 1 stays IDLE with tx_disable[1]=1.
- Timeout: rx_ready=0 -> BACKOFF entered 64 cycles after WAIT_RX entry, fail_cnt[0]=1; chan_rst reasserted for 16 cycles, then RESET retried.
- Flap: rx_ready drops on debounce cycle 5 -> back to WAIT_RX, no count; stable high afterwards -> UP. A later drop in UP -> BACKOFF, fail_cnt=1.
- Abort: pll_locked=0 while UP -> both channels IDLE next edge, link_up=0, chan_rst=1, fail_cnt unchanged.
- Saturation/clear: force 20 timeouts -> fail_cnt=15 held. fail_clr on the same cycle as an increment -> 0.
- Async reset during DEBOUNCE -> outputs at reset values without any clock edge.
